// File: rtl/psum_accum.sv
// -----------------------------------------------------------------------------
// psum_accum
//
// Partial-sum accumulator for the convolution datapath. Sums a per-window
// number of signed terms on top of a bias, saturating at every addition, and
// optionally clamps a negative result to zero (ReLU). The finished result is
// handed downstream through a valid/ready handshake. While a result is held,
// no new term is accepted.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    in_data carries a term this cycle
//   in_ready    block accepts a term this cycle
//   in_data     signed operand (from the upstream 2:1 mux)
//   cfg_len     terms per window (0 behaves as 1), sampled on the first term
//   cfg_relu    clamp negative results to 0, sampled on the first term
//   bias        signed bias, added once with the first term
//   first_term  next accepted term opens a window (upstream mux select)
//   out_valid   out_data holds a finished result
//   out_ready   downstream takes the result
//   out_data    signed, registered result
// -----------------------------------------------------------------------------
`ifndef INTERNAL_BITS
`define INTERNAL_BITS 32
`endif

module psum_accum #(
  parameter int DATA_W = `INTERNAL_BITS,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic              cfg_relu,
  input  logic [DATA_W-1:0] bias,
  output logic              first_term,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_e;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [CNT_W-1:0]  len_q,   len_d;
  logic              relu_q,  relu_d;
  logic [DATA_W-1:0] acc_q,   acc_d;
  logic [DATA_W-1:0] out_q,   out_d;

  logic              accept;
  logic              is_first;
  logic              is_last;
  logic [DATA_W-1:0] lhs;
  logic [DATA_W:0]   sum_wide;
  logic [DATA_W-1:0] sum_sat;
  logic [CNT_W-1:0]  len_eff;
  logic              relu_eff;
  logic [CNT_W:0]    cnt_inc;

  // ---------------------------------------------------------------------------
  // Datapath: saturating add and window bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    is_first = (cnt_q == '0);
    accept   = in_valid && (state_q == ST_ACC);

    // The first term of a window starts from the bias instead of the
    // running sum, so the bias needs no separate cycle.
    lhs      = is_first ? bias : acc_q;
    sum_wide = {lhs[DATA_W-1], lhs} + {in_data[DATA_W-1], in_data};

    // The two top bits of the widened sum disagree only on overflow; the
    // extra bit carries the true sign and selects the clamp direction.
    if (sum_wide[DATA_W] != sum_wide[DATA_W-1]) begin
      sum_sat = sum_wide[DATA_W] ? SAT_MIN : SAT_MAX;
    end else begin
      sum_sat = sum_wide[DATA_W-1:0];
    end

    // On the first term the live configuration is used directly, since the
    // latched copies only become visible on the next cycle. This lets a
    // one-term window finish on its first accept.
    len_eff  = is_first ? ((cfg_len == '0) ? CNT_ONE : cfg_len) : len_q;
    relu_eff = is_first ? cfg_relu : relu_q;

    cnt_inc  = {1'b0, cnt_q} + (CNT_W+1)'(1);
    is_last  = accept && (cnt_inc == {1'b0, len_eff});
  end

  always_comb begin
    cnt_d  = cnt_q;
    len_d  = len_q;
    relu_d = relu_q;
    acc_d  = acc_q;
    out_d  = out_q;
    if (accept) begin
      acc_d = sum_sat;
      if (is_first) begin
        len_d  = len_eff;
        relu_d = cfg_relu;
      end
      if (is_last) begin
        cnt_d = '0;
        out_d = (relu_eff && sum_sat[DATA_W-1]) ? '0 : sum_sat;
      end else begin
        cnt_d = cnt_inc[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      len_q  <= CNT_ONE;
      relu_q <= 1'b0;
      acc_q  <= '0;
      out_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      relu_q <= relu_d;
      acc_q  <= acc_d;
      out_q  <= out_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACC: if (is_last)   state_d = ST_OUT;
      ST_OUT: if (out_ready) state_d = ST_ACC;
      default:               state_d = ST_ACC;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM: output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready   = (state_q == ST_ACC);
    out_valid  = (state_q == ST_OUT);
    first_term = (state_q == ST_ACC) && is_first;
    out_data   = out_q;
  end

endmodule

// File: tb/tb_psum_accum.sv
module tb_psum_accum;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] cfg_len;
  logic          cfg_relu;
  logic [DW-1:0] bias;
  logic          first_term;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  int vectors     = 0;
  int miscompares = 0;

  psum_accum #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .cfg_len    (cfg_len),
    .cfg_relu   (cfg_relu),
    .bias       (bias),
    .first_term (first_term),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  // Reference: exact integer sum clamped to the 32-bit range after each term.
  function automatic logic [DW-1:0] ref_window(input logic [DW-1:0] b,
                                               input logic [DW-1:0] terms[$],
                                               input bit relu);
    longint acc;
    acc = longint'($signed(b));
    foreach (terms[i]) begin
      acc = acc + longint'($signed(terms[i]));
      if (acc > SMAX) acc = SMAX;
      else if (acc < SMIN) acc = SMIN;
    end
    if (relu && acc < 0) acc = 0;
    return acc[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return DW'($urandom_range(0, 200)) - DW'(100);
      1:       return 32'h7FFF_0000 + DW'($urandom_range(0, 32'hFFFF));
      2:       return 32'h8000_0000 + DW'($urandom_range(0, 32'hFFFF));
      default: return DW'($urandom());
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_term(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; cfg_len = '0;
    cfg_relu = 1'b0; bias = '0; out_ready = 1'b0;
    #2;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++; if (first_term !== 1'b1) begin miscompares++; $display("FAIL reset_first_term: got %b want 1", first_term); end
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    out_ready = 1'b1; cfg_len = 8'd4; bias = 32'd10; cfg_relu = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++; if (first_term !== (k == 0)) begin miscompares++; $display("FAIL basic_first_term[%0d]: got %b want %b", k, first_term, (k == 0)); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_in_ready[%0d]: got %b want 1", k, in_ready); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid[%0d]: got %b want 0", k, out_valid); end
      drive_term(DW'(k + 1));
    end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_out_valid: got %b want 1", out_valid); end
    vectors++; if (out_data !== 32'd20) begin miscompares++; $display("FAIL basic_out_data: got %h want %h", out_data, 32'd20); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_in_ready_out: got %b want 0", in_ready); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid_drop: got %b want 0", out_valid); end
    vectors++; if (first_term !== 1'b1) begin miscompares++; $display("FAIL basic_first_again: got %b want 1", first_term); end
  endtask

  task automatic test_relu();
    logic [DW-1:0] exp_v [2] = '{32'hFFFF_FFFD, 32'h0};
    out_ready = 1'b1; cfg_len = 8'd2; bias = '0;
    for (int r = 0; r < 2; r++) begin
      cfg_relu = 1'(r);
      drive_term(-DW'(5));
      drive_term(DW'(2));
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL relu_valid[%0d]: got %b want 1", r, out_valid); end
      vectors++; if (out_data !== exp_v[r]) begin miscompares++; $display("FAIL relu_data[%0d]: got %h want %h", r, out_data, exp_v[r]); end
      step();
    end
    cfg_relu = 1'b0;
  endtask

  task automatic test_saturation();
    logic [DW-1:0] sb [3] = '{32'h7FFF_FFF0, 32'h8000_0010, 32'h7FFF_FFF0};
    logic [DW-1:0] s0 [3] = '{32'h0000_0100, 32'hFFFF_FF00, 32'h0000_0100};
    logic [DW-1:0] s1 [3] = '{32'h0000_0100, 32'hFFFF_FF00, 32'hFFFF_FFFF};
    logic [DW-1:0] se [3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFE};
    out_ready = 1'b1; cfg_len = 8'd2; cfg_relu = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bias = sb[i];
      drive_term(s0[i]);
      drive_term(s1[i]);
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL sat_valid[%0d]: got %b want 1", i, out_valid); end
      vectors++; if (out_data !== se[i]) begin miscompares++; $display("FAIL sat_data[%0d]: got %h want %h", i, out_data, se[i]); end
      step();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; cfg_len = 8'd2; bias = 32'd50; cfg_relu = 1'b0;
    drive_term(32'd3);
    drive_term(32'd4);
    vectors++; if (out_data !== 32'd57) begin miscompares++; $display("FAIL bp_data: got %h want %h", out_data, 32'd57); end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = DW'(1000 + c);
      step();
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", c, out_valid); end
      vectors++; if (out_data !== 32'd57) begin miscompares++; $display("FAIL bp_hold_data[%0d]: got %h want %h", c, out_data, 32'd57); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", c, in_ready); end
    end
    out_ready = 1'b1;
    in_data   = 32'd2000;
    step();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    vectors++; if (first_term !== 1'b1) begin miscompares++; $display("FAIL bp_release_first: got %b want 1", first_term); end
    bias = 32'd100;
    drive_term(32'd7);
    drive_term(32'd8);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_next_valid: got %b want 1", out_valid); end
    vectors++; if (out_data !== 32'd115) begin miscompares++; $display("FAIL bp_next_data: got %h want %h", out_data, 32'd115); end
    step();
  endtask

  task automatic test_len0_latch();
    out_ready = 1'b1; cfg_len = 8'd0; bias = 32'd7; cfg_relu = 1'b0;
    drive_term(32'd5);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL len0_valid: got %b want 1", out_valid); end
    vectors++; if (out_data !== 32'd12) begin miscompares++; $display("FAIL len0_data: got %h want %h", out_data, 32'd12); end
    step();
    cfg_len = 8'd3; bias = 32'd1;
    drive_term(-DW'(10));
    cfg_len = 8'd1; bias = 32'd999; cfg_relu = 1'b1;
    drive_term(32'd2);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL latch_early_valid: got %b want 0", out_valid); end
    drive_term(32'd3);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL latch_valid: got %b want 1", out_valid); end
    vectors++; if (out_data !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL latch_data: got %h want %h", out_data, 32'hFFFF_FFFC); end
    step();
    cfg_relu = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1; cfg_len = 8'd4; bias = '0; cfg_relu = 1'b0;
    drive_term(32'd1);
    drive_term(32'd1);
    rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL rstmid_data: got %h want 0", out_data); end
    vectors++; if (first_term !== 1'b1) begin miscompares++; $display("FAIL rstmid_first: got %b want 1", first_term); end
    #1;
    rst_n = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) drive_term(32'd1);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_next_valid: got %b want 1", out_valid); end
    vectors++; if (out_data !== 32'd4) begin miscompares++; $display("FAIL rstmid_next_data: got %h want %h", out_data, 32'd4); end
    step();
    rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstout_valid: got %b want 0", out_valid); end
    vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL rstout_data: got %h want 0", out_data); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstout_ready: got %b want 1", in_ready); end
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_random();
    logic [DW-1:0] m_terms[$];
    logic [DW-1:0] m_bias = '0;
    logic [DW-1:0] m_last = '0;
    int            m_len  = 1;
    bit            m_relu = 1'b0;
    bit            m_hold = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rand_operand();
      cfg_len   = CW'($urandom_range(0, 5));
      cfg_relu  = 1'($urandom_range(0, 1));
      bias      = rand_operand();
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      vectors++; if (in_ready !== !m_hold) begin miscompares++; $display("FAIL rand_in_ready@%0d: got %b want %b", cyc, in_ready, !m_hold); end
      vectors++; if (out_valid !== m_hold) begin miscompares++; $display("FAIL rand_out_valid@%0d: got %b want %b", cyc, out_valid, m_hold); end
      vectors++; if (first_term !== (!m_hold && m_terms.size() == 0)) begin miscompares++; $display("FAIL rand_first_term@%0d: got %b want %b", cyc, first_term, (!m_hold && m_terms.size() == 0)); end
      vectors++; if (out_data !== m_last) begin miscompares++; $display("FAIL rand_out_data@%0d: got %h want %h", cyc, out_data, m_last); end
      if (!m_hold) begin
        if (in_valid) begin
          if (m_terms.size() == 0) begin
            m_len  = (cfg_len == '0) ? 1 : int'(cfg_len);
            m_relu = cfg_relu;
            m_bias = bias;
          end
          m_terms.push_back(in_data);
          if (m_terms.size() == m_len) begin
            m_last = ref_window(m_bias, m_terms, m_relu);
            m_hold = 1'b1;
            m_terms.delete();
          end
        end
      end else if (out_ready) begin
        m_hold = 1'b0;
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_saturation();
    test_backpressure();
    test_len0_latch();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/psum_accum.md
# psum_accum

Partial-sum accumulator for the convolution datapath. Consumes the 32-bit signed operand stream produced by `MUX2to1_32b`, sums a configurable number of terms per output window on top of a bias, and applies saturation and optional ReLU. Results are presented through a valid/ready handshake. It also drives `first_term`, which the upstream mux uses as its select to distinguish the first operand of a window.

## Interface
- `DATA_W`, default `` `INTERNAL_BITS `` (32): operand and result width, two's-complement signed.
- `CNT_W`, default 8: width of the window-length field and of the internal term counter.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  block accepts a term this cycle.
- `in_data`  in  DATA_W  signed operand, taken from `MUX2to1_32b` `Data_out`.
- `cfg_len`  in  CNT_W  terms per window. A value of 0 is treated as 1.
- `cfg_relu`  in  1  1 = clamp negative results to 0.
- `bias`  in  DATA_W  signed bias added once per window.
- `first_term`  out  1  next accepted term is the first of a window.
- `out_valid`  out  1  `out_data` holds a finished result.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  DATA_W  signed result.

## Operation
- The state machine has two states.
  - ACC: accepting terms.
  - OUT: holding a result.
  - The reset state is ACC.
- Output decode:
  - `in_ready` = (state == ACC).
  - `out_valid` = (state == OUT).
  - `first_term` = (state == ACC) && (cnt == 0).
- A term is accepted when `in_valid && in_ready`.
- First accepted term of a window (cnt == 0):
  - Latch `len_q` = max(`cfg_len`, 1) and `relu_q` = `cfg_relu`.
  - Set `acc` = sat(`bias` + `in_data`).
  - Changes to `cfg_len`, `cfg_relu` or `bias` after the first term are ignored until the next window.
- Subsequent accepted terms: `acc` = sat(`acc` + `in_data`).
- `cnt` increments on each accepted term.
- When the accepted term makes cnt+1 == `len_q`:
  - `out_data` <= (`relu_q` && result < 0) ? 0 : result.
  - `cnt` <= 0.
  - Go to OUT.
- sat():
  - Compute the sum at DATA_W+1 bits.
  - Positive overflow clamps to 0x7FFFFFFF.
  - Negative overflow clamps to 0x80000000.
  - Saturation is applied at every addition, not only at window end.
- OUT state:
  - `out_data` is held stable and `in_ready` = 0. `in_valid` is ignored and not consumed.
  - On `out_valid && out_ready`, go to ACC.
- Reset (asynchronous, any cycle, including mid-window or in OUT):
  - state = ACC, `cnt` = 0, `acc` = 0, `out_data` = 0, `len_q` = 1, `relu_q` = 0.
  - Any partial window is discarded.
- Reset values of outputs:
  - `out_valid` = 0, `out_data` = 0.
  - `in_ready` = 1, `first_term` = 1; no term is accepted until the first clock edge after `rst_n` rises.

## Timing
- Accept rate: one term per cycle while in ACC.
- Latency: if the last term of a window is accepted at edge t, `out_valid` = 1 after edge t.
- Result hand-off: if `out_ready` = 1 in the first OUT cycle, the state returns to ACC after the next edge. This gives exactly one bubble cycle per window; a window of L terms takes at least L+1 cycles.
- `out_data` is registered and changes only on entry to OUT or on reset.
- `out_valid` never drops without a handshake, except on reset.
- `first_term` is combinational from registered state and is valid in the same cycle the mux uses it.

## Test plan
- Basic window.
  - Stimulus: `cfg_len`=4, `bias`=10, `cfg_relu`=0, terms 1,2,3,4 on consecutive cycles, `out_ready`=1.
  - Response: `out_data`=20, `out_valid` high one cycle after the 4th accept. `first_term` is high only before the 1st term.
- Sign and ReLU.
  - Stimulus: `cfg_len`=2, `bias`=0, terms -5,2.
  - Response: with `cfg_relu`=0, `out_data`=0xFFFFFFFD. With `cfg_relu`=1, `out_data`=0.
- Saturation.
  - Positive: `bias`=0x7FFFFFF0, terms 0x100,0x100 → 0x7FFFFFFF.
  - Negative: `bias`=0x80000010, terms -0x100,-0x100 → 0x80000000.
  - Mid-window clamp: `bias`=0x7FFFFFF0, terms 0x100,-1 → 0x7FFFFFFE.
- Backpressure.
  - Stimulus: hold `out_ready`=0 for 5 cycles after the result, with `in_valid`=1 and changing `in_data`.
  - Response: `out_data` is stable, `in_ready`=0, and no term is consumed. After `out_ready`=1, the next window starts with the value present when `in_ready` returns to 1.
- Length 0 and config latching.
  - Stimulus: `cfg_len`=0, `bias`=7, term 5. Then a second window with `cfg_len`=3, where `cfg_len` changes to 1 after the first term.
  - Response: the first window gives 12. The second window still sums 3 terms.
- Reset mid-window.
  - Stimulus: `cfg_len`=4, accept 2 terms, then pulse `rst_n` low between edges.
  - Response: `out_valid`=0 and `out_data`=0 immediately. The next window of 4 terms 1,1,1,1 with `bias`=0 gives 4.
